// File: rtl/dual_fetch_buffer.sv
`default_nettype none
// dual_fetch_buffer: 2-wide in / 2-wide out circular fetch buffer feeding a dual decoder. Rev 1.0
// Optional macro DUAL_FETCH_BYPASS_EN: zero-latency bypass of incoming fetch into empty output slots.
package dual_fetch_buffer_pkg;
  typedef logic [31:0] instruction_s;
endpackage

module dual_fetch_buffer
  import dual_fetch_buffer_pkg::*;
#(
  parameter int els_p      = 4,
  parameter int pc_width_p = 22
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic         [1:0]             enq_v_i,
  input  instruction_s [1:0]             enq_instr_i,
  input  logic         [pc_width_p-1:0]  enq_pc_i,
  output logic                           enq_ready_o,
  output instruction_s [1:0]             instr_o,
  output logic [1:0]   [pc_width_p-1:0]  pc_o,
  output logic         [1:0]             instr_v_o,
  input  logic         [1:0]             deq_cnt_i,
  output logic [$clog2(els_p+1)-1:0]     count_o
);

  localparam int PTR_W = $clog2(els_p);
  localparam int CNT_W = $clog2(els_p + 1);

  logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d, rd1, wr1;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            n_enq;
  logic [1:0]            n_valid;
  instruction_s          mem_instr_q [els_p];
  logic [pc_width_p-1:0] mem_pc_q    [els_p];

  assign rd1         = rd_q + PTR_W'(1);
  assign wr1         = wr_q + PTR_W'(1);
  assign enq_ready_o = (count_q <= CNT_W'(els_p - 2));
  assign count_o     = count_q;

  always_comb begin
    n_enq = 2'd0;
    if (enq_ready_o && !flush_i && enq_v_i[0]) begin
      n_enq = enq_v_i[1] ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      wr_d    = wr_q + PTR_W'(n_enq);
      rd_d    = rd_q + PTR_W'(deq_cnt_i);
      count_d = count_q + CNT_W'(n_enq) - CNT_W'(deq_cnt_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; invalid slots are don't-care.
  always_ff @(posedge clk_i) begin
    if (!reset_i && n_enq != 2'd0) begin
      mem_instr_q[wr_q] <= enq_instr_i[0];
      mem_pc_q[wr_q]    <= enq_pc_i;
      if (n_enq == 2'd2) begin
        mem_instr_q[wr1] <= enq_instr_i[1];
        mem_pc_q[wr1]    <= enq_pc_i + pc_width_p'(1);
      end
    end
  end

  always_comb begin
    instr_o[0]   = mem_instr_q[rd_q];
    instr_o[1]   = mem_instr_q[rd1];
    pc_o[0]      = mem_pc_q[rd_q];
    pc_o[1]      = mem_pc_q[rd1];
    instr_v_o[0] = (count_q != '0);
    instr_v_o[1] = (count_q > CNT_W'(1));
`ifdef DUAL_FETCH_BYPASS_EN
    // Empty output slots show the incoming fetch; it is still written so a same-cycle dequeue stays consistent.
    if (count_q < CNT_W'(2) && enq_ready_o && !flush_i) begin
      if (count_q == '0) begin
        instr_o[0]   = enq_instr_i[0];
        pc_o[0]      = enq_pc_i;
        instr_v_o[0] = enq_v_i[0];
        instr_o[1]   = enq_instr_i[1];
        pc_o[1]      = enq_pc_i + pc_width_p'(1);
        instr_v_o[1] = enq_v_i[0] & enq_v_i[1];
      end else begin
        instr_o[1]   = enq_instr_i[0];
        pc_o[1]      = enq_pc_i;
        instr_v_o[1] = enq_v_i[0];
      end
    end
`endif
  end

  assign n_valid = {1'b0, instr_v_o[0]} + {1'b0, instr_v_o[1]};

  a_enq_v_legal: assert property (@(posedge clk_i) disable iff (reset_i) enq_v_i != 2'b10);
  a_deq_legal:   assert property (@(posedge clk_i) disable iff (reset_i) deq_cnt_i <= n_valid);

endmodule
`default_nettype wire

// File: tb/tb_dual_fetch_buffer.sv
`default_nettype none
// tb_dual_fetch_buffer: directed and random checks of dual_fetch_buffer against a queue model.
module tb_dual_fetch_buffer;
  import dual_fetch_buffer_pkg::*;

  localparam int ELS = 4;
  localparam int PCW = 22;

  typedef struct packed {
    instruction_s   instr;
    logic [PCW-1:0] pc;
  } ent_t;

  logic                          clk_i = 1'b0;
  logic                          reset_i, flush_i;
  logic         [1:0]            enq_v_i, deq_cnt_i;
  instruction_s [1:0]            enq_instr_i;
  logic         [PCW-1:0]        enq_pc_i;
  logic                          enq_ready_o;
  instruction_s [1:0]            instr_o;
  logic [1:0]   [PCW-1:0]        pc_o;
  logic         [1:0]            instr_v_o;
  logic [$clog2(ELS+1)-1:0]      count_o;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  ent_t view[$];

  always #5 clk_i = ~clk_i;

  dual_fetch_buffer #(.els_p(ELS), .pc_width_p(PCW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .enq_v_i(enq_v_i), .enq_instr_i(enq_instr_i), .enq_pc_i(enq_pc_i),
    .enq_ready_o(enq_ready_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_v_o(instr_v_o), .deq_cnt_i(deq_cnt_i), .count_o(count_o)
  );

  function automatic bit bypass_on();
`ifdef DUAL_FETCH_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic ent_t mk(input instruction_s ins, input logic [PCW-1:0] pc);
    ent_t e;
    e.instr = ins;
    e.pc    = pc;
    return e;
  endfunction

  // Instructions the decoder can see this cycle, given the pending fetch and flush.
  function automatic int vis(input bit fl, input logic [1:0] ev);
    int n = q.size();
    if (bypass_on() && n < 2 && !fl) n += (ev[0] ? 1 : 0) + ((ev == 2'b11) ? 1 : 0);
    return (n > 2) ? 2 : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rs, input bit fl, input logic [1:0] ev,
                       input logic [1:0] dq, input logic [PCW-1:0] pc);
    bit rdy;
    int nv;
    reset_i        = rs;
    flush_i        = fl;
    enq_v_i        = ev;
    deq_cnt_i      = dq;
    enq_pc_i       = pc;
    enq_instr_i[0] = $urandom;
    enq_instr_i[1] = $urandom;
    #4;
    rdy  = (ELS - q.size()) >= 2;
    view = q;
    if (bypass_on() && q.size() < 2 && !fl) begin
      if (ev[0])        view.push_back(mk(enq_instr_i[0], pc));
      if (ev == 2'b11)  view.push_back(mk(enq_instr_i[1], pc + PCW'(1)));
    end
    nv = vis(fl, ev);
    chk("count", 64'(count_o), 64'(q.size()));
    chk("ready", 64'(enq_ready_o), 64'(rdy));
    chk("valid", 64'(instr_v_o), (nv == 0) ? 64'd0 : (nv == 1) ? 64'd1 : 64'd3);
    for (int k = 0; k < nv; k++) begin
      chk($sformatf("pc%0d", k), 64'(pc_o[k]), 64'(view[k].pc));
      chk($sformatf("instr%0d", k), 64'(instr_o[k]), 64'(view[k].instr));
    end
    @(posedge clk_i);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (rdy && ev[0])       q.push_back(mk(enq_instr_i[0], pc));
      if (rdy && ev == 2'b11) q.push_back(mk(enq_instr_i[1], pc + PCW'(1)));
      for (int i = 0; i < dq; i++) void'(q.pop_front());
    end
    #1;
  endtask

  initial begin
    bit         rs, fl;
    logic [1:0] ev, dq;
    int         r;
    reset_i     = 1'b1;
    flush_i     = 1'b0;
    enq_v_i     = 2'b00;
    deq_cnt_i   = 2'b00;
    enq_pc_i    = '0;
    enq_instr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    q.delete();

    cycle(1, 0, 2'b00, 2'd0, PCW'('h0));
    cycle(0, 0, 2'b11, 2'd0, PCW'('h10));
    cycle(0, 0, 2'b11, 2'd0, PCW'('h12));
    cycle(0, 0, 2'b11, 2'd0, PCW'('h20));
    repeat (4) cycle(0, 0, 2'b00, 2'd1, PCW'('h0));
    cycle(0, 0, 2'b00, 2'd0, PCW'('h0));
    cycle(0, 0, 2'b11, 2'd0, PCW'('h30));
    cycle(0, 0, 2'b11, 2'd2, PCW'('h40));
    cycle(0, 0, 2'b01, 2'd0, PCW'('h50));
    cycle(0, 1, 2'b11, 2'd1, PCW'('h60));
    cycle(0, 0, 2'b00, 2'd0, PCW'('h0));

    for (int it = 0; it < 600; it++) begin
      r  = int'($urandom_range(0, 99));
      rs = (r == 0);
      fl = (r >= 1 && r <= 4);
      case ($urandom_range(0, 2))
        0:       ev = 2'b00;
        1:       ev = 2'b01;
        default: ev = 2'b11;
      endcase
      dq = 2'($urandom_range(0, vis(fl, ev)));
      cycle(rs, fl, ev, dq, PCW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
